// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO responder: register word addresses,
// the bus window base used by the memory stage to decode `sel`, and
// byte-lane write helpers.
`timescale 1ns/1ps
package gpio_pkg;

    // Base byte address of the GPIO register window on the data port
    localparam logic [31:0] GPIO_BASE = 32'h8000_0000;

    // Word addresses inside the window
    typedef enum logic [2:0] {
        GPIO_OUT     = 3'd0,
        GPIO_DIR     = 3'd1,
        GPIO_IN      = 3'd2,
        GPIO_RISE_EN = 3'd3,
        GPIO_PEND    = 3'd4,
        GPIO_FALL_EN = 3'd5
    } gpio_reg_e;

    // Expand four byte-lane enables into a 32-bit bit mask
    function automatic logic [31:0] lane_mask(input logic [3:0] we);
        lane_mask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    endfunction

    // Replace only the enabled byte lanes of cur with wdata
    function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  we);
        logic [31:0] m;
        m = lane_mask(we);
        lane_merge = (cur & ~m) | (wdata & m);
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// WIDTH x SYNC_STAGES flip-flop synchroniser for asynchronous pad inputs.
// Output q is the last stage; all stages clear on asynchronous reset.
`timescale 1ns/1ps
module gpio_sync #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [SYNC_STAGES];

    // Shift the pad sample through the synchroniser chain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_port.sv
// Memory-mapped GPIO responder: OUT/DIR/IN/RISE_EN/PEND registers, pad
// tristate drive, synchronised input and edge-triggered pending bits
// feeding a registered level irq.
// Optional falling-edge interrupts (FALL_EN at word 5) are built when the
// macro GPIO_FALL_EDGE_EN is defined; otherwise word 5 reads 0.
// ADDR_W must be at least 3; words outside 0..5 read 0 and ignore writes.
`timescale 1ns/1ps
module gpio_port
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    inout  wire  [WIDTH-1:0]  gpio,
    output logic              irq
);

    logic             wr_req;
    logic             rd_req;
    logic             in_window;
    gpio_reg_e        reg_sel;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] rise_en_q;
    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] prev_p;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] pend_clr;
    logic [31:0]      clr_word;
    logic [31:0]      rd_mux;

    logic             wr_out;
    logic             wr_dir;
    logic             wr_rise;
    logic             wr_pend;
`ifdef GPIO_FALL_EDGE_EN
    logic [WIDTH-1:0] fall_en_q;
    logic             wr_fall;
`endif

    // Zero-extend a pin-wide value onto the 32-bit bus
    function automatic logic [31:0] widen(input logic [WIDTH-1:0] v);
        widen = '0;
        widen[WIDTH-1:0] = v;
    endfunction

    // Byte-lane write into a pin-wide register
    function automatic logic [WIDTH-1:0] merge_reg(input logic [WIDTH-1:0] cur,
                                                   input logic [31:0]      data,
                                                   input logic [3:0]       lanes);
        logic [31:0] merged;
        merged = lane_merge(widen(cur), data, lanes);
        merge_reg = merged[WIDTH-1:0];
    endfunction

    assign wr_req    = sel && (we != 4'b0000);
    assign rd_req    = sel && (we == 4'b0000);
    assign in_window = ((addr >> 3) == '0);
    assign reg_sel   = gpio_reg_e'(addr[2:0]);

    // Input synchroniser; IN sees every pad, including ones we drive
    gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (gpio),
        .q     (sync_s)
    );

    // Pad drive: OUT when the direction bit is set, otherwise released
    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    // Decode which register a write targets
    always_comb begin
        wr_out  = 1'b0;
        wr_dir  = 1'b0;
        wr_rise = 1'b0;
        wr_pend = 1'b0;
`ifdef GPIO_FALL_EDGE_EN
        wr_fall = 1'b0;
`endif
        if (wr_req && in_window) begin
            case (reg_sel)
                GPIO_OUT:     wr_out  = 1'b1;
                GPIO_DIR:     wr_dir  = 1'b1;
                GPIO_RISE_EN: wr_rise = 1'b1;
                GPIO_PEND:    wr_pend = 1'b1;
`ifdef GPIO_FALL_EDGE_EN
                GPIO_FALL_EN: wr_fall = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    // Select the register value returned on a read
    always_comb begin
        rd_mux = '0;
        if (in_window) begin
            case (reg_sel)
                GPIO_OUT:     rd_mux = widen(out_q);
                GPIO_DIR:     rd_mux = widen(dir_q);
                GPIO_IN:      rd_mux = widen(sync_s);
                GPIO_RISE_EN: rd_mux = widen(rise_en_q);
                GPIO_PEND:    rd_mux = widen(pend_q);
`ifdef GPIO_FALL_EDGE_EN
                GPIO_FALL_EN: rd_mux = widen(fall_en_q);
`endif
                default:      rd_mux = '0;
            endcase
        end
    end

    // Write-1-to-clear mask restricted to the enabled byte lanes
    assign clr_word = lane_mask(we) & wdata;
    assign pend_clr = wr_pend ? clr_word[WIDTH-1:0] : '0;

`ifdef GPIO_FALL_EDGE_EN
    assign edge_set = (sync_s & ~prev_p & rise_en_q) | (~sync_s & prev_p & fall_en_q);
`else
    assign edge_set = sync_s & ~prev_p & rise_en_q;
`endif

    // Software-writable configuration registers, byte-lane granular
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
        end else begin
            if (wr_out)  out_q     <= merge_reg(out_q, wdata, we);
            if (wr_dir)  dir_q     <= merge_reg(dir_q, wdata, we);
            if (wr_rise) rise_en_q <= merge_reg(rise_en_q, wdata, we);
        end
    end

`ifdef GPIO_FALL_EDGE_EN
    // Falling-edge enable register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fall_en_q <= '0;
        end else if (wr_fall) begin
            fall_en_q <= merge_reg(fall_en_q, wdata, we);
        end
    end
`endif

    // Previous synchroniser sample; both start at 0 so no edge right after reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_p <= '0;
        end else begin
            prev_p <= sync_s;
        end
    end

    // Pending bits: software clear, with a new edge on the same bit winning
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~pend_clr) | edge_set;
        end
    end

    // Registered irq level and read data (zero after any non-read cycle)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq   <= 1'b0;
            rdata <= '0;
        end else begin
            irq   <= |pend_q;
            rdata <= rd_req ? rd_mux : 32'h0;
        end
    end

endmodule

// File: tb/tb_gpio_port.sv
// Testbench for gpio_port: reset state, a register-access vector table,
// hand-written interrupt/reset sequences and a randomized run against a
// queue-based reference model. Honours GPIO_FALL_EDGE_EN like the design.
`timescale 1ns/1ps
module tb_gpio_port;

    localparam int SYNC = 2;

    logic        clk;
    logic        reset;
    logic        sel;
    logic [3:0]  we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    wire  [31:0] gpio;

    logic [31:0] tb_drv;
    logic [31:0] tb_en;

    int checks;
    int failures;

    gpio_port #(
        .WIDTH       (32),
        .SYNC_STAGES (SYNC),
        .ADDR_W      (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .gpio  (gpio),
        .irq   (irq)
    );

    // External pad drivers, only enabled on pins the DUT is not driving
    for (genvar i = 0; i < 32; i++) begin : g_ext
        assign gpio[i] = tb_en[i] ? tb_drv[i] : 1'bz;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [3:0] w, input logic [2:0] a, input logic [31:0] d);
        sel = s; we = w; addr = a; wdata = d;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 4'h0, 3'd0, 32'h0);
        repeat (n) step();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        drive(1'b1, 4'hF, a, d);
        step();
        drive(1'b0, 4'h0, 3'd0, 32'h0);
    endtask

    task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        drive(1'b1, 4'h0, a, 32'h0);
        step();
        check(name, rdata, exp);
        drive(1'b0, 4'h0, 3'd0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 4'h0, 3'd0, 32'h0);
        tb_en  = 32'hFFFF_FFFF;
        tb_drv = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    // ---------------- reference model ----------------
    logic [31:0] out_m, dir_m, rise_m, fall_m, pend_m, rdata_m;
    logic        irq_m;
    logic [31:0] hist [0:SYNC];   // hist[0] = pad value sampled at the latest edge

    function automatic logic [31:0] lanes(input logic [3:0] w);
        logic [31:0] m;
        m = 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (w[b]) m[8*b +: 8] = 8'hFF;
        end
        return m;
    endfunction

    task automatic model_reset();
        out_m = 0; dir_m = 0; rise_m = 0; fall_m = 0; pend_m = 0;
        rdata_m = 0; irq_m = 1'b0;
        for (int j = 0; j <= SYNC; j++) hist[j] = 32'h0;
    endtask

    // Effect of one rising clock edge given the inputs currently applied
    task automatic model_step();
        logic [31:0] s_v, p_v, m, pad_now, set_v, clr_v, rd_v;
        logic        wr_v;
        s_v     = hist[SYNC-1];
        p_v     = hist[SYNC];
        pad_now = (dir_m & out_m) | (~dir_m & tb_drv);
        m       = lanes(we);
        wr_v    = sel && (we != 4'h0);
        rd_v    = 32'h0;
        if (sel && we == 4'h0) begin
            case (addr)
                3'd0: rd_v = out_m;
                3'd1: rd_v = dir_m;
                3'd2: rd_v = s_v;
                3'd3: rd_v = rise_m;
                3'd4: rd_v = pend_m;
                3'd5: rd_v = fall_m;
                default: rd_v = 32'h0;
            endcase
        end
        set_v = s_v & ~p_v & rise_m;
`ifdef GPIO_FALL_EDGE_EN
        set_v = set_v | (~s_v & p_v & fall_m);
`endif
        clr_v  = (wr_v && addr == 3'd4) ? (wdata & m) : 32'h0;
        irq_m  = (pend_m != 32'h0);
        pend_m = (pend_m & ~clr_v) | set_v;
        if (wr_v) begin
            case (addr)
                3'd0: out_m  = (out_m & ~m) | (wdata & m);
                3'd1: dir_m  = (dir_m & ~m) | (wdata & m);
                3'd3: rise_m = (rise_m & ~m) | (wdata & m);
`ifdef GPIO_FALL_EDGE_EN
                3'd5: fall_m = (fall_m & ~m) | (wdata & m);
`endif
                default: ;
            endcase
        end
        for (int j = SYNC; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = pad_now;
        rdata_m = rd_v;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        s;
        logic [3:0]  w;
        logic [2:0]  a;
        logic [31:0] d;
        logic [31:0] en;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [20];

    logic        r_sel;
    logic [3:0]  r_we;
    logic [2:0]  r_addr;
    logic [31:0] r_wdata;
    logic [31:0] exp_fall;
    bit          got_irq;

    initial begin
        checks   = 0;
        failures = 0;
        vecs[0]  = '{1'b1, 4'hF, 3'd1, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0};
        vecs[1]  = '{1'b1, 4'hF, 3'd0, 32'h0000_0000, 32'hFFFF_0000, 32'h0};
        vecs[2]  = '{1'b1, 4'h2, 3'd0, 32'hAABB_CCDD, 32'hFFFF_0000, 32'h0};
        vecs[3]  = '{1'b1, 4'h0, 3'd0, 32'h0,         32'hFFFF_0000, 32'h0000_CC00};
        vecs[4]  = '{1'b1, 4'hF, 3'd0, 32'h1234_5678, 32'hFFFF_0000, 32'h0};
        vecs[5]  = '{1'b1, 4'h0, 3'd0, 32'h0,         32'hFFFF_0000, 32'h1234_5678};
        vecs[6]  = '{1'b1, 4'h0, 3'd1, 32'h0,         32'hFFFF_0000, 32'h0000_FFFF};
        vecs[7]  = '{1'b0, 4'h0, 3'd1, 32'h0,         32'hFFFF_0000, 32'h0};
        vecs[8]  = '{1'b1, 4'h0, 3'd3, 32'h0,         32'hFFFF_0000, 32'h0};
        vecs[9]  = '{1'b1, 4'h1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'h0};
        vecs[10] = '{1'b1, 4'h0, 3'd3, 32'h0,         32'hFFFF_0000, 32'h0000_00FF};
        vecs[11] = '{1'b1, 4'hF, 3'd3, 32'h0,         32'hFFFF_0000, 32'h0};
        vecs[12] = '{1'b1, 4'h0, 3'd4, 32'h0,         32'hFFFF_0000, 32'h0};
        vecs[13] = '{1'b1, 4'hF, 3'd6, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'h0};
        vecs[14] = '{1'b1, 4'h0, 3'd6, 32'h0,         32'hFFFF_0000, 32'h0};
        vecs[15] = '{1'b1, 4'h0, 3'd7, 32'h0,         32'hFFFF_0000, 32'h0};
        vecs[16] = '{1'b1, 4'hF, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'h0};
        vecs[17] = '{1'b1, 4'h0, 3'd2, 32'h0,         32'hFFFF_0000, 32'hA5A5_5678};
        vecs[18] = '{1'b1, 4'h0, 3'd5, 32'h0,         32'hFFFF_0000, 32'h0};
        vecs[19] = '{1'b1, 4'h0, 3'd0, 32'h0,         32'hFFFF_0000, 32'h1234_5678};

        // ---- reset state ----
        reset  = 1'b0;
        drive(1'b0, 4'h0, 3'd0, 32'h0);
        tb_en  = 32'hFFFF_FFFF;
        tb_drv = 32'h0F0F_0F0F;
        repeat (3) @(negedge clk);
        #1;
        check("rst_rdata", rdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_pads_released", gpio, 32'h0F0F_0F0F);
        reset = 1'b1;
        idle(3);
        rd_check("rst_dir", 3'd1, 32'h0);
        rd_check("rst_pend", 3'd4, 32'h0);
        rd_check("rst_in", 3'd2, 32'h0F0F_0F0F);

        // ---- register access table ----
        tb_drv = 32'hA5A5_0000;
        for (int k = 0; k < 20; k++) begin
            drive(vecs[k].s, vecs[k].w, vecs[k].a, vecs[k].d);
            tb_en = vecs[k].en;
            step();
            check($sformatf("vec%0d_rdata", k), rdata, vecs[k].exp);
        end
        drive(1'b0, 4'h0, 3'd0, 32'h0);
        check("table_pads", gpio, 32'hA5A5_5678);

        // ---- rising edge raises PEND and irq, W1C clears ----
        do_reset();
        wr(3'd3, 32'h1);
        idle(4);
        tb_drv[0] = 1'b1;
        got_irq = 1'b0;
        for (int n = 0; n < SYNC + 2 && !got_irq; n++) begin
            step();
            got_irq = irq;
        end
        check("rise_irq_within_bound", {31'h0, got_irq}, 32'h1);
        rd_check("rise_pend", 3'd4, 32'h1);
        wr(3'd4, 32'h1);
        check("irq_lags_clear", {31'h0, irq}, 32'h1);
        idle(1);
        check("irq_after_clear", {31'h0, irq}, 32'h0);
        rd_check("pend_cleared", 3'd4, 32'h0);

        // ---- edge coinciding with a clear write: set wins ----
        tb_drv[0] = 1'b0;
        idle(5);
        tb_drv[0] = 1'b1;
        idle(2);
        drive(1'b1, 4'hF, 3'd4, 32'h1);
        step();
        drive(1'b1, 4'h0, 3'd4, 32'h0);
        step();
        check("set_wins_pend", rdata, 32'h1);
        idle(1);
        check("set_wins_irq", {31'h0, irq}, 32'h1);

        // ---- reset mid-operation ----
        do_reset();
        wr(3'd3, 32'h3);
        wr(3'd1, 32'hFFFF_FFFF);
        tb_en = 32'h0;
        idle(2);
        wr(3'd0, 32'h3);
        idle(6);
        check("pre_rst_pads", gpio, 32'h3);
        check("pre_rst_irq", {31'h0, irq}, 32'h1);
        rd_check("pre_rst_pend", 3'd4, 32'h3);
        #2;
        reset  = 1'b0;
        tb_en  = 32'hFFFF_FFFF;
        tb_drv = 32'h5A5A_5A5A;
        #1;
        check("rst_mid_pads_z", gpio, 32'h5A5A_5A5A);
        check("rst_mid_irq", {31'h0, irq}, 32'h0);
        check("rst_mid_rdata", rdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        idle(1);
        check("post_rst_irq", {31'h0, irq}, 32'h0);
        check("post_rst_rdata", rdata, 32'h0);
        rd_check("post_rst_pend", 3'd4, 32'h0);
        rd_check("post_rst_dir", 3'd1, 32'h0);

        // ---- falling edge (feature dependent) ----
`ifdef GPIO_FALL_EDGE_EN
        exp_fall = 32'h2;
`else
        exp_fall = 32'h0;
`endif
        do_reset();
        tb_drv[1] = 1'b1;
        idle(6);
        wr(3'd5, 32'h2);
        rd_check("fall_en_read", 3'd5, exp_fall);
        tb_drv[1] = 1'b0;
        idle(6);
        rd_check("fall_pend", 3'd4, exp_fall);
        check("fall_irq", {31'h0, irq}, {31'h0, exp_fall[1]});

        // ---- randomized run against the reference model ----
        do_reset();
        model_reset();
        for (int n = 0; n < 500; n++) begin
            r_sel   = ($urandom_range(0, 9) != 0);
            r_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            r_addr  = 3'($urandom_range(0, 7));
            r_wdata = $urandom;
            if ($urandom_range(0, 2) == 0) tb_drv = $urandom;
            drive(r_sel, r_we, r_addr, r_wdata);
            model_step();
            @(negedge clk);
            tb_en = ~dir_m;
            #1;
            check("rnd_rdata", rdata, rdata_m);
            check("rnd_irq", {31'h0, irq}, {31'h0, irq_m});
            check("rnd_pads", gpio, (dir_m & out_m) | (~dir_m & tb_drv));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
